mul_rr_sched: RTL and testbench
===============================

# mul_rr_sched

Round-robin scheduler that shares one registered 6x6 signed multiplier (11-bit product, one-cycle latency, hold-when-disabled) among NREQ requesters. Accepts one operand pair at a time over a valid/ready handshake, drives the multiplier's operand and enable inputs, captures the returned product, and presents it with the requester ID on a single valid/ready response port. Sits between the multiply clients and the shared array multiplier instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- IDW, 2, requester ID width, equal to clog2(NREQ)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_a  in  6*NREQ  signed multiplicand; slice i = req_a[6i+5:6i]
- req_b  in  6*NREQ  signed multiplier; same slicing
- req_ready  out  NREQ  one-hot accept strobe, combinational
- mul_a  out  6  operand A to the shared multiplier
- mul_b  out  6  operand B to the shared multiplier
- mul_en  out  1  multiplier enable; one-cycle pulse per operation
- mul_p  in  11  registered product from the multiplier
- rsp_valid  out  1  response valid, registered
- rsp_id  out  IDW  index of the requester that owns rsp_p
- rsp_p  out  11  signed product
- rsp_ovf  out  1  set when both operands were -32 (true product +1024 wraps to -1024 in 11 bits)
- rsp_ready  in  1  response consumer ready
- busy  out  1  high in WAIT or RESP

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid is set, grant the first set bit at or after ptr, scanning upward modulo NREQ. Assert req_ready[g] for exactly that cycle. Drive mul_a/mul_b from slice g and set mul_en=1. Latch g into id_r and (a==-32 && b==-32) into ovf_r. Set ptr to (g+1) mod NREQ and go to WAIT. If no req_valid is set, remain in IDLE; ptr is unchanged.
- WAIT: mul_en=0. mul_p is valid this cycle. Capture rsp_p<=mul_p, rsp_id<=id_r, rsp_ovf<=ovf_r, and rsp_valid<=1. Go to RESP.
- RESP: hold rsp_* stable. When rsp_ready=1, clear rsp_valid and go to IDLE. No new grant is made in RESP.
- Outside the IDLE grant cycle: mul_a=0, mul_b=0, mul_en=0, req_ready=0.
- Requesters hold req_valid and operands until accepted. Operands are sampled only in the grant cycle.
- Product width: rsp_p is mul_p unmodified. No saturation; overflow is reported only through rsp_ovf.
- Reset values: state=IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_p=0, rsp_ovf=0, busy=0. Combinational outputs are inactive. Reset mid-operation abandons the in-flight product; no response is emitted for it.

## Timing
- Accept at cycle T (IDLE, req_valid[g]&req_ready[g]). mul_en=1 at T. mul_p is valid at T+1. rsp_valid=1 from T+2.
- Latency from accept to rsp_valid is 2 cycles.
- With rsp_ready held high: rsp_valid lasts 1 cycle (T+2), IDLE is reached at T+3, and the next accept can occur at T+3. Peak throughput is one operation per 3 cycles.
- If rsp_ready is low, RESP holds indefinitely. All requests stall; none are dropped.
- Simultaneous requests: the winner is determined solely by ptr. Each requester waits at most NREQ grants for service.
- A req_valid deasserted before acceptance withdraws the request without any side effect.

## Test plan
- Reset then single request: req_valid=4'b0100, a=5, b=-3, rsp_ready=1 -> req_ready=4'b0100 and mul_en=1 in the same cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_p=-15, rsp_ovf=0; busy drops the cycle after.
- All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,...; accepts spaced exactly 3 cycles apart; each rsp_p matches its requester's a*b.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* stable throughout, req_ready=0, mul_en=0; rsp_ready=1 -> next grant 1 cycle later.
- Overflow corner: a=-32, b=-32 -> rsp_p=11'h400 (-1024), rsp_ovf=1. Also a=-32, b=31 -> rsp_p=-992, rsp_ovf=0.
- Pointer fairness: requester 3 only, then requesters 0 and 3 together -> requester 0 wins (ptr wrapped to 0); next grant goes to 3.
- Async reset asserted in WAIT -> outputs at reset values immediately; after release, no stale response appears and the first grant goes to the lowest valid index at or after 0.

Source files
------------

// File: rtl/mul_rr_sched.sv
`default_nettype none
//============================================================================//
//  Module   : mul_rr_sched                                                   //
//  Purpose  : Round-robin scheduler sharing one registered 6x6 signed        //
//             multiplier (11-bit product, one-cycle latency, holds its       //
//             output when not enabled) among NREQ requesters.                //
//                                                                            //
//  Ports    : clk        - clock, rising edge                                //
//             rst_n      - asynchronous active-low reset                     //
//             req_valid  - per-requester request valid           [NREQ]      //
//             req_a      - signed multiplicands, 6 bits each     [6*NREQ]    //
//             req_b      - signed multipliers, 6 bits each       [6*NREQ]    //
//             req_ready  - one-hot accept strobe (combinational) [NREQ]      //
//             mul_a      - operand A to the shared multiplier    [6]         //
//             mul_b      - operand B to the shared multiplier    [6]         //
//             mul_en     - multiplier enable, one pulse per operation        //
//             mul_p      - registered product from the multiplier [11]       //
//             rsp_valid  - response valid (registered)                       //
//             rsp_id     - requester index owning rsp_p          [IDW]       //
//             rsp_p      - signed product, unmodified            [11]        //
//             rsp_ovf    - both operands were -32 (product wrapped)          //
//             rsp_ready  - response consumer ready                           //
//             busy       - high while an operation is in flight              //
//                                                                            //
//  Revision : 1.0 - initial release                                          //
//============================================================================//
module mul_rr_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [6*NREQ-1:0] req_a,
    input  logic [6*NREQ-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [5:0]        mul_a,
    output logic [5:0]        mul_b,
    output logic              mul_en,
    input  logic [10:0]       mul_p,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [10:0]       rsp_p,
    output logic              rsp_ovf,
    input  logic              rsp_ready,
    output logic              busy
);

    //------------------------------------------------------------------------
    // State encoding
    //------------------------------------------------------------------------
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_wait = 2'd1;
    localparam logic [1:0] c_st_resp = 2'd2;

    // Most negative 6-bit value; -32 * -32 = +1024 does not fit in 11 bits.
    localparam logic [5:0] c_min_op = 6'b10_0000;

    //------------------------------------------------------------------------
    // Registers
    //------------------------------------------------------------------------
    logic [1:0]     r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic           r_ovf;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [10:0]    r_rsp_p;
    logic           r_rsp_ovf;

    //------------------------------------------------------------------------
    // Combinational signals
    //------------------------------------------------------------------------
    logic [1:0]      w_state_nxt;
    logic            w_any;
    logic [IDW-1:0]  w_gnt;
    logic [IDW-1:0]  w_ptr_nxt;
    logic            w_accept;
    logic [5:0]      w_a [NREQ];
    logic [5:0]      w_b [NREQ];
    logic [IDW:0]    w_sum;
    logic [IDW-1:0]  w_idx;

    //------------------------------------------------------------------------
    // Operand slicing into per-requester arrays
    //------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign w_a[gi] = req_a[6*gi +: 6];
            assign w_b[gi] = req_b[6*gi +: 6];
        end
    endgenerate

    //------------------------------------------------------------------------
    // Round-robin search: first valid requester at or after r_ptr, modulo
    // NREQ. The sum is one bit wider than the index so the wrap works for
    // any NREQ, not just powers of two.
    //------------------------------------------------------------------------
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_sum = '0;
        w_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_any && req_valid[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    // Pointer moves just past the winner so it gets lowest priority next time.
    always_comb begin
        if (w_gnt == IDW'(NREQ-1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gnt + IDW'(1);
        end
    end

    //------------------------------------------------------------------------
    // FSM next-state and combinational outputs
    //------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        mul_a       = '0;
        mul_b       = '0;
        mul_en      = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_any) begin
                    w_accept         = 1'b1;
                    req_ready[w_gnt] = 1'b1;
                    mul_a            = w_a[w_gnt];
                    mul_b            = w_b[w_gnt];
                    mul_en           = 1'b1;
                    w_state_nxt      = c_st_wait;
                end
            end
            c_st_wait: begin
                // Product appears on mul_p during this cycle.
                w_state_nxt = c_st_resp;
            end
            c_st_resp: begin
                if (rsp_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // State register and request bookkeeping
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
            r_ptr   <= '0;
            r_id    <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_ptr <= w_ptr_nxt;
                r_id  <= w_gnt;
                r_ovf <= (w_a[w_gnt] == c_min_op) && (w_b[w_gnt] == c_min_op);
            end
        end
    end

    //------------------------------------------------------------------------
    // Response registers: loaded from the multiplier in WAIT, held in RESP
    // until the consumer takes them.
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_p     <= '0;
            r_rsp_ovf   <= 1'b0;
        end else begin
            if (r_state == c_st_wait) begin
                r_rsp_valid <= 1'b1;
                r_rsp_id    <= r_id;
                r_rsp_p     <= mul_p;
                r_rsp_ovf   <= r_ovf;
            end else if ((r_state == c_st_resp) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_p     = r_rsp_p;
    assign rsp_ovf   = r_rsp_ovf;
    assign busy      = (r_state == c_st_wait) || (r_state == c_st_resp);

endmodule
`default_nettype wire

// File: tb/tb_mul_rr_sched.sv
`default_nettype none
//============================================================================//
//  Module   : tb_mul_rr_sched                                                //
//  Purpose  : Directed self-checking bench for mul_rr_sched with a           //
//             behavioural model of the shared registered multiplier.         //
//  Revision : 1.0 - initial release                                          //
//============================================================================//
module tb_mul_rr_sched;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [6*NREQ-1:0] req_a;
    logic [6*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic [5:0]        mul_a;
    logic [5:0]        mul_b;
    logic              mul_en;
    logic [10:0]       mul_p;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [10:0]       rsp_p;
    logic              rsp_ovf;
    logic              rsp_ready;
    logic              busy;

    int checks = 0;
    int errors = 0;

    mul_rr_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_en    (mul_en),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .rsp_ovf   (rsp_ovf),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared multiplier model: registered, one-cycle latency, holds when idle.
    logic signed [10:0] w_ax;
    logic signed [10:0] w_bx;
    assign w_ax = {{5{mul_a[5]}}, mul_a};
    assign w_bx = {{5{mul_b[5]}}, mul_b};
    initial mul_p = '0;
    always @(posedge clk) begin
        if (mul_en) begin
            mul_p <= w_ax * w_bx;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input int a, input int b);
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        req_a[6*i +: 6] = av[5:0];
        req_b[6*i +: 6] = bv[5:0];
    endtask

    // Raise the requests in vmask (on top of any already pending), expect
    // requester g to win, then follow the operation to its response with
    // rsp_ready high. Starts and ends just after a rising edge in IDLE.
    task automatic run_op(input logic [3:0] vmask, input int g, input logic [10:0] p,
                          input logic ovf, input string tag);
        req_valid = req_valid | vmask;
        #1;
        check({tag, "_ready"}, 32'(req_ready), 32'(1) << g);
        check({tag, "_mul_en"}, 32'(mul_en), 32'd1);
        tick();
        req_valid[g] = 1'b0;
        check({tag, "_wait_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_wait_busy"}, 32'(busy), 32'd1);
        tick();
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_rsp_id"}, 32'(rsp_id), 32'(g));
        check({tag, "_rsp_p"}, 32'(rsp_p), 32'(p));
        check({tag, "_rsp_ovf"}, 32'(rsp_ovf), 32'(ovf));
        tick();
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    endtask

    logic [10:0] exp_p [4];

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        exp_p[0]  = 11'h7EC;   //  10 *  -2 =  -20
        exp_p[1]  = 11'h03F;   //  -7 *  -9 =   63
        exp_p[2]  = 11'h3C1;   //  31 *  31 =  961
        exp_p[3]  = 11'h7E0;   // -32 *   1 =  -32

        // Reset state
        tick();
        tick();
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_p", 32'(rsp_p), 32'd0);
        check("rst_rsp_ovf", 32'(rsp_ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_mul_en", 32'(mul_en), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single request from requester 2: 5 * -3 = -15
        set_op(2, 5, -3);
        req_valid = 4'b0100;
        #1;
        check("single_mul_a", 32'(mul_a), 32'h05);
        check("single_mul_b", 32'(mul_b), 32'h3D);
        req_valid = 4'b0000;
        #1;
        req_valid = 4'b0000;
        run_op(4'b0100, 2, 11'h7F1, 1'b0, "single");
        check("single_busy_drop", 32'(busy), 32'd0);

        // Overflow corner from requester 3 (ptr is now 3): -32 * -32 wraps
        set_op(3, -32, -32);
        run_op(4'b1000, 3, 11'h400, 1'b1, "ovf");

        // ptr wrapped to 0: requesters 0 and 3 together, 0 wins, then 3
        set_op(0, -32, 31);
        set_op(3, 7, 7);
        run_op(4'b1001, 0, 11'h420, 1'b0, "fair0");
        run_op(4'b1000, 3, 11'h031, 1'b0, "fair3");

        // Backpressure: requester 1 (-4 * 6 = -24), requester 0 queued behind
        set_op(1, -4, 6);
        set_op(0, 3, 3);
        rsp_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        check("bp_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = 4'b0001;
        #1;
        check("bp_wait_ready", 32'(req_ready), 32'd0);
        tick();
        for (int n = 0; n < 10; n++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_id", 32'(rsp_id), 32'd1);
            check("bp_hold_p", 32'(rsp_p), 32'h7E8);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            check("bp_hold_mul_en", 32'(mul_en), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        #1;
        check("bp_next_ready", 32'(req_ready), 32'b0001);
        check("bp_next_mul_en", 32'(mul_en), 32'd1);
        tick();
        req_valid = 4'b0000;
        tick();
        check("bp_next_rsp_id", 32'(rsp_id), 32'd0);
        check("bp_next_rsp_p", 32'(rsp_p), 32'h009);
        tick();

        // Async reset while WAITing for requester 2's product
        set_op(2, 2, 2);
        req_valid = 4'b0100;
        #1;
        check("rw_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = 4'b0000;
        check("rw_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rw_rsp_p", 32'(rsp_p), 32'd0);
        check("rw_rsp_id", 32'(rsp_id), 32'd0);
        check("rw_mul_en", 32'(mul_en), 32'd0);
        check("rw_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rw_no_stale0", 32'(rsp_valid), 32'd0);
        tick();
        check("rw_no_stale1", 32'(rsp_valid), 32'd0);
        check("rw_idle_busy", 32'(busy), 32'd0);

        // All four requesting continuously: order 0,1,2,3,0,1 every 3 cycles
        set_op(0, 10, -2);
        set_op(1, -7, -9);
        set_op(2, 31, 31);
        set_op(3, -32, 1);
        req_valid = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            #1;
            check("rr_ready", 32'(req_ready), 32'(1) << (n % 4));
            check("rr_mul_en", 32'(mul_en), 32'd1);
            tick();
            check("rr_gap1_ready", 32'(req_ready), 32'd0);
            tick();
            check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rr_rsp_id", 32'(rsp_id), 32'(n % 4));
            check("rr_rsp_p", 32'(rsp_p), 32'(exp_p[n % 4]));
            check("rr_rsp_ovf", 32'(rsp_ovf), 32'd0);
            check("rr_gap2_ready", 32'(req_ready), 32'd0);
            tick();
        end
        req_valid = 4'b0000;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
